// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus bundle between the CPU (master) and an MMIO responder (slave).
// Requests are single-cycle strobes on mem_oe; read responses return one cycle later
// on mem_ready with the data on mem_rdata.
interface mmio_uart_tx_if;
    logic        mem_oe;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_oe,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_oe,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the processor data bus.
// DATA register: writes push a byte into the TX FIFO, reads return "TX available".
// STATUS register: flags, sticky overflow (write bit3=1 to clear) and FIFO occupancy.
// Read responses are registered and strobed on mem_ready exactly one cycle after the request.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'hf0000100,
    parameter int unsigned DIV       = 868,
    parameter int unsigned FIFO_LOG  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mmio_uart_tx_if.slave     bus,
    output logic              txd
);

    localparam int unsigned Depth     = 2 ** FIFO_LOG;
    localparam logic [31:0] StatAddr  = BASE_ADDR + 32'd4;
    localparam logic [15:0] DivM1     = 16'(DIV - 1);

    typedef logic [FIFO_LOG:0] ptr_t;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic hit_data;
    logic hit_stat;
    logic wr_lane0;
    logic is_read;
    logic push;
    logic drop;
    logic ovf_clr;
    logic rd_req;

    // FIFO state
    ptr_t       wptr_q;
    ptr_t       rptr_q;
    ptr_t       count;
    logic       full;
    logic       empty;
    logic [7:0] fifo_mem [Depth];
    logic [7:0] head;
    logic       pop;

    // Serializer state
    state_e     state_q;
    logic [15:0] timer_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic       txd_q;
    logic       timer_done;
    logic       busy;

    // Registers and read path
    logic        ovf_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic [31:0] data_val;
    logic [31:0] stat_val;

    // Address LSBs and upper write-data bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata[31:8]};

    // Request classification; everything is ignored while reset is held.
    always_comb begin
        hit_data = rst && bus.mem_oe && (bus.mem_addr[31:2] == BASE_ADDR[31:2]);
        hit_stat = rst && bus.mem_oe && (bus.mem_addr[31:2] == StatAddr[31:2]);
        wr_lane0 = bus.mem_we[0];
        is_read  = (bus.mem_we == 4'b0000);
        // Full is judged on the current pointers, before any same-cycle pop.
        push     = hit_data && wr_lane0 && !full;
        drop     = hit_data && wr_lane0 && full;
        ovf_clr  = hit_stat && wr_lane0 && bus.mem_wdata[3];
        rd_req   = (hit_data || hit_stat) && is_read;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    // Pointer-derived flags; the extra wrap bit distinguishes full from empty.
    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[FIFO_LOG] != rptr_q[FIFO_LOG]) &&
                (wptr_q[FIFO_LOG-1:0] == rptr_q[FIFO_LOG-1:0]);
        count = wptr_q - rptr_q;
        head  = fifo_mem[rptr_q[FIFO_LOG-1:0]];
    end

    // Read and write pointers; they wrap naturally modulo 2*Depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + ptr_t'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + ptr_t'(1);
            end
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q[FIFO_LOG-1:0]] <= bus.mem_wdata[7:0];
        end
    end

    // Sticky overflow: set by a dropped push, cleared by a STATUS write with bit3 set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------

    // Pop decisions: from IDLE immediately, or at the end of STOP for a gap-free next frame.
    always_comb begin
        timer_done = (timer_q == 16'd0);
        busy       = (state_q != StIdle);
        pop        = rst && !empty &&
                     ((state_q == StIdle) || ((state_q == StStop) && timer_done));
    end

    // 8N1 frame sequencer with registered txd; each bit lasts DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= head;
                        timer_q <= DivM1;
                        txd_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (timer_done) begin
                        timer_q   <= DivM1;
                        bit_idx_q <= 3'd0;
                        txd_q     <= shift_q[0];
                        state_q   <= StData;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                StData: begin
                    if (timer_done) begin
                        timer_q <= DivM1;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                StStop: begin
                    if (timer_done) begin
                        if (pop) begin
                            shift_q <= head;
                            timer_q <= DivM1;
                            txd_q   <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    timer_q <= 16'd0;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------

    // Register images as seen at the request edge.
    always_comb begin
        data_val    = {31'b0, !full};
        stat_val    = '0;
        stat_val[0] = !full;
        stat_val[1] = empty;
        stat_val[2] = busy;
        stat_val[3] = ovf_q;
        stat_val[8 +: FIFO_LOG+1] = count;
    end

    // One-cycle read response; data is forced to zero whenever no response is strobed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= rd_req;
            if (rd_req) begin
                rdata_q <= hit_data ? data_val : stat_val;
            end else begin
                rdata_q <= 32'd0;
            end
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign txd           = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with DIV=4: read-response scoreboard plus a serial
// monitor that reconstructs every frame sample-by-sample against expected bytes.
module tb_mmio_uart_tx;

    localparam int unsigned Div      = 4;
    localparam int unsigned FrameLen = 10 * Div;
    localparam logic [31:0] Base     = 32'hf0000100;
    localparam logic [31:0] Stat     = Base + 32'd4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic txd;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR (Base),
        .DIV       (Div),
        .FIFO_LOG  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .txd (txd)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] val;
        int unsigned due;
        string       tag;
    } rd_t;

    rd_t        rd_q[$];
    logic [7:0] byte_q[$];

    int unsigned n_frames   = 0;
    int unsigned last_start = 0;
    bit          b2b_check  = 1'b0;
    bit          b2b_seen   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read scoreboard: mem_ready must appear exactly at the due cycle, rdata zero otherwise.
    always @(negedge clk) begin
        bit exp_ready;
        exp_ready = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        check("mem_ready", 64'(bus.mem_ready), 64'(exp_ready));
        if (exp_ready) begin
            rd_t e;
            e = rd_q.pop_front();
            check(e.tag, 64'(bus.mem_rdata), 64'(e.val));
        end else begin
            check("rdata_idle_zero", 64'(bus.mem_rdata), 64'd0);
        end
    end

    // Serial monitor: a low sample starts a frame; all 10*Div samples are compared at once.
    always begin
        @(negedge clk);
        if (txd === 1'b0) begin
            int unsigned           st;
            logic [7:0]            exp_b;
            bit                    have;
            bit                    aborted;
            logic [FrameLen-1:0]   obs;
            logic [FrameLen-1:0]   expv;
            st      = cyc;
            have    = (byte_q.size() > 0);
            exp_b   = have ? byte_q.pop_front() : 8'h00;
            aborted = (rst !== 1'b1);
            if (b2b_check && b2b_seen) begin
                check("b2b_start", 64'(st), 64'(last_start + FrameLen));
            end
            if (b2b_check) b2b_seen = 1'b1;
            last_start = st;
            obs[0] = txd;
            for (int i = 1; i < FrameLen; i++) begin
                @(negedge clk);
                obs[i] = txd;
                if (rst !== 1'b1) aborted = 1'b1;
            end
            if (!aborted) begin
                for (int i = 0; i < FrameLen; i++) begin
                    int b;
                    b = i / Div;
                    if (b == 0)      expv[i] = 1'b0;
                    else if (b == 9) expv[i] = 1'b1;
                    else             expv[i] = exp_b[b-1];
                end
                check("frame_expected", 64'(have), 64'd1);
                check("frame_bits", 64'(obs), 64'(expv));
                n_frames++;
            end
        end
    end

    task automatic bus_drive(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] we);
        @(posedge clk);
        #1;
        bus.mem_oe    = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        bus.mem_we    = we;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        rd_t e;
        bus_drive(addr, 32'h0, 4'b0000);
        e.val = exp;
        e.due = cyc + 1;
        e.tag = tag;
        rd_q.push_back(e);
    endtask

    task automatic bus_idle();
        @(posedge clk);
        #1;
        bus.mem_oe = 1'b0;
        bus.mem_we = 4'b0000;
    endtask

    task automatic wait_frames(input int unsigned n, input int unsigned budget);
        int unsigned k;
        k = 0;
        while (n_frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("frames_done", 64'(n_frames), 64'(n));
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int unsigned t0;
        int unsigned nf;
        bus.mem_oe    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_we    = 4'b0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_txd", 64'(txd), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        bus_read(Stat, 32'h0000_0003, "stat_after_reset");
        bus_idle();
        wait_cycles(3);

        // Single frame 0x55 with start latency and busy flag
        nf = n_frames;
        byte_q.push_back(8'h55);
        bus_drive(Base, 32'h0000_0055, 4'b0001);
        t0 = cyc;
        bus_idle();
        wait_cycles(8);
        bus_read(Stat, 32'h0000_0007, "stat_mid_frame");
        bus_read(Base, 32'h0000_0001, "data_not_full");
        bus_idle();
        wait_frames(nf + 1, 200);
        check("start_latency", 64'(last_start), 64'(t0 + 2));
        wait_cycles(3);
        bus_read(Stat, 32'h0000_0003, "stat_after_frame");
        bus_idle();
        wait_cycles(3);

        // Overflow burst: 0x40 starts a frame, then 17 writes fill 16 slots and drop one
        nf = n_frames;
        b2b_check = 1'b1;
        b2b_seen  = 1'b0;
        byte_q.push_back(8'h40);
        bus_drive(Base, 32'h0000_0040, 4'b0001);
        bus_idle();
        wait_cycles(2);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) byte_q.push_back(8'(8'h41 + i));
            bus_drive(Base, 32'(8'h41 + i), 4'b0001);
        end
        bus_read(Stat, 32'h0000_100c, "stat_full_ovf");
        bus_read(Base, 32'h0000_0000, "data_full");
        bus_drive(Stat, 32'h0000_0008, 4'b0001);
        bus_read(Stat, 32'h0000_1004, "stat_ovf_cleared");
        bus_idle();
        wait_frames(nf + 17, 17 * FrameLen + 200);
        b2b_check = 1'b0;
        wait_cycles(3);
        bus_read(Stat, 32'h0000_0003, "stat_drained");
        bus_idle();
        wait_cycles(3);

        // Non-effects: wrong byte lane, unmapped address (write and read)
        nf = n_frames;
        bus_drive(Base, 32'h0000_0041, 4'b1110);
        bus_drive(Base + 32'd8, 32'h0000_0042, 4'b0001);
        bus_drive(Base + 32'd8, 32'h0, 4'b0000);
        bus_idle();
        wait_cycles(4);
        bus_read(Stat, 32'h0000_0003, "stat_no_effect");
        bus_idle();
        wait_cycles(2 * FrameLen);
        @(negedge clk);
        check("txd_stays_idle", 64'(txd), 64'd1);
        check("no_frame", 64'(n_frames), 64'(nf));

        // Back-to-back reads; the scoreboard also checks rdata returns to zero after
        bus_read(Base, 32'h0000_0001, "b2b_data");
        bus_read(Stat, 32'h0000_0003, "b2b_stat");
        bus_idle();
        wait_cycles(3);

        // Reset during DATA with three bytes queued; a write in the reset cycle is ignored
        nf = n_frames;
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        byte_q.push_back(8'h33);
        bus_drive(Base, 32'h0000_0011, 4'b0001);
        bus_drive(Base, 32'h0000_0022, 4'b0001);
        bus_drive(Base, 32'h0000_0033, 4'b0001);
        bus_idle();
        wait_cycles(15);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_oe    = 1'b1;
        bus.mem_addr  = Base;
        bus.mem_wdata = 32'h0000_0099;
        bus.mem_we    = 4'b0001;
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.mem_oe = 1'b0;
        bus.mem_we = 4'b0000;
        byte_q.delete();
        @(negedge clk);
        check("txd_after_reset", 64'(txd), 64'd1);
        bus_read(Stat, 32'h0000_0003, "stat_after_midreset");
        bus_idle();
        wait_cycles(4 * FrameLen);
        @(negedge clk);
        check("no_frames_after_reset", 64'(n_frames), 64'(nf));
        check("txd_final_idle", 64'(txd), 64'd1);
        check("reads_all_answered", 64'(rd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Hardware memory-mapped UART transmitter and responder on the PROCESSOR data bus (mem_* signals). Replaces the simulation-only console MMIO for FPGA builds.
- CPU stores bytes into a TX FIFO.
- An 8N1 serializer drains the FIFO onto txd.
- Status reads use the single-cycle read-response protocol the PROCESSOR expects (mem_ready pulse one cycle after the request).

Parameters:
- BASE_ADDR, 32'hf0000100, word-aligned address of the DATA register; STATUS register is at BASE_ADDR+4.
- DIV, 868, clocks per UART bit (100 MHz / 115200); legal range 2..65535.
- FIFO_LOG, 4, log2 of TX FIFO depth (depth 16).

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-low.
- mem_oe  input  1  bus request valid, one cycle per request.
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_we  input  4  byte write enables; all zero means read.
- mem_rdata  output  32  read data, valid only while mem_ready=1.
- mem_ready  output  1  read response strobe.
- txd  output  1  serial output, idle high.

Behaviour:
- Decode:
  - hit_data = mem_oe && mem_addr[31:2]==BASE_ADDR[31:2].
  - hit_stat = mem_oe && mem_addr[31:2]==(BASE_ADDR+4)[31:2].
  - mem_addr[1:0] is ignored. Non-hits produce no response and no side effect.
- Write DATA (hit_data, mem_we[0]=1):
  - Pushes mem_wdata[7:0] into the FIFO if not full.
  - If full, the byte is dropped and the sticky ovf flag is set.
  - mem_we[0]=0 with other lanes set: no effect.
- Full is evaluated before any same-cycle pop: a push while full is dropped even if the serializer pops that cycle.
- Write STATUS (hit_stat, mem_we[0]=1): mem_wdata[3]=1 clears ovf. Other bits are ignored.
- Writes never assert mem_ready.
- Read (hit, mem_we==0):
  - mem_ready=1 exactly on the next cycle. Back-to-back reads give back-to-back ready pulses.
  - mem_rdata is the value registered at the request edge. It is 0 whenever mem_ready=0.
- DATA read value: {31'b0, !full}. Nonzero means TX available, which is what the console putchar polls.
- STATUS read value, LSB first:
  - bit0 = !full
  - bit1 = empty
  - bit2 = busy (serializer not IDLE)
  - bit3 = ovf
  - bits[8+:FIFO_LOG+1] = FIFO occupancy count
  - all other bits 0
- FIFO:
  - Circular buffer, 2**FIFO_LOG entries, read/write pointers FIFO_LOG+1 bits wide (extra wrap bit).
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - Count = wptr - rptr, modulo 2**(FIFO_LOG+1).
  - Pointers wrap naturally.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> (IDLE or START).
  - IDLE: txd=1. If FIFO not empty, pop the head into the shift register, load the bit timer with DIV-1, go to START.
  - START: txd=0 for DIV cycles.
  - DATA: txd = shift[0], LSB first. 8 bits, each DIV cycles; shift right and increment bit index 0..7 at each timer expiry.
  - STOP: txd=1 for DIV cycles. On expiry, if FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Frame is exactly 10*DIV cycles. Bit timer counts down to 0; expiry happens at timer==0.
- Latency: a write sampled at edge k on an idle, empty block puts the byte in the FIFO after k. IDLE pops at edge k+1. txd falls after edge k+1.
- txd and mem_rdata are registered outputs (no combinational path from inputs).
- Reset (rst=0 at a clock edge), also when asserted mid-frame or mid-read:
  - txd=1, mem_ready=0, mem_rdata=0.
  - FSM=IDLE, FIFO emptied (pointers=0), ovf=0, timer=0.
  - A bus request in a reset cycle is ignored.

Test Plan:
- DIV=4: write 0x55 to DATA -> txd low from cycle k+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; STATUS bit2=1 during the frame, 0 after.
- DIV=4: 17 consecutive writes 0x41..0x51 to DATA with txd stalled (FIFO filling faster than drain) -> 17th dropped; STATUS reads bit3=1, bit0=0, count=16 (or 15 if one popped). Then 16 frames 0x41..0x50 emitted back-to-back with no idle gap.
- Read DATA while not full -> mem_ready=1 next cycle only, mem_rdata=1. When full -> mem_rdata=0. Write STATUS 0x8 -> subsequent STATUS bit3=0.
- Write DATA with mem_we=4'b1110, and a write to BASE_ADDR+8 -> FIFO count stays 0, no mem_ready, txd stays 1.
- Back-to-back reads of DATA then STATUS on consecutive cycles -> two consecutive mem_ready pulses with the correct respective values; mem_rdata=0 in the following cycle.
- Assert rst=0 for one cycle in the middle of the DATA state with 3 bytes queued -> txd=1 next cycle, STATUS=0x00000003 (not full, empty), no further frames.
